input_conditioner: RTL and testbench



---
 rtl/input_conditioner_pkg.sv | 10 +
 rtl/input_conditioner_debounce_bit.sv | 86 ++++++++
 rtl/input_conditioner.sv | 56 +++++
 tb/tb_input_conditioner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// tt_input_pkg: shared pin map and debounce defaults for the reaction-game input stage.
package tt_input_pkg;
    localparam int BTN_LSB = 4;
    localparam int BTN_MSB = 7;
    localparam int DSW_LSB = 0;
    localparam int DSW_MSB = 3;
    localparam int TICK_DIV_DEFAULT = 20_000;
    localparam int STABLE_TICKS_DEFAULT = 5;
    typedef logic [BTN_MSB-BTN_LSB:0] btn_t;
endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: per-pin synchronizer, tick-based stability counter and edge pulses.
// Long-press counter is built only with INPUT_CONDITIONER_LONG_PRESS_EN defined.
module debounce_bit #(
    parameter int STABLE_TICKS = 5,
    parameter int LONG_TICKS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic hold
);
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_TICKS - 1);

    logic sync1, sync2;
    logic [SW-1:0] cnt;

    if (STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_param
        $error("debounce_bit: STABLE_TICKS and LONG_TICKS must be >= 1");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any cycle where the input agrees with the accepted level restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (ena) begin
                if (sync2 == level) cnt <= '0;
                else if (tick) begin
                    if (cnt == S_LAST) begin
                        level <= sync2;
                        cnt   <= '0;
                        rise  <= sync2;
                        fall  <= !sync2;
                    end else cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] H_MAX = HW'(LONG_TICKS);

    logic [HW-1:0] hcnt;

    // Saturating at H_MAX guarantees a single hold pulse per press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            hold <= 1'b0;
        end else begin
            hold <= 1'b0;
            if (ena) begin
                if (!level) hcnt <= '0;
                else if (tick && hcnt != H_MAX) begin
                    hcnt <= hcnt + 1'b1;
                    hold <= (hcnt == H_MAX - 1'b1);
                end
            end
        end
    end
`else
    assign hold = 1'b0;
`endif
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces ui_in pins into levels and press/release pulses.
// Define INPUT_CONDITIONER_LONG_PRESS_EN to enable the per-bit long-press hold pulse.
module input_conditioner
    import tt_input_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int LONG_TICKS = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_rise,
    output logic             tick,
    output logic [WIDTH-1:0] hold
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;

    if (TICK_DIV < 2) begin : g_bad_div
        $error("input_conditioner: TICK_DIV must be >= 2");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pcnt <= '0;
        else if (ena) pcnt <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
    end

    // Gated by ena so a frozen prescaler never emits a tick.
    assign tick     = ena && (pcnt == P_LAST);
    assign any_rise = |rise;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS),
            .LONG_TICKS  (LONG_TICKS)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .ena  (ena),
            .tick (tick),
            .raw  (raw_in[i]),
            .level(level[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .hold (hold[i])
        );
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench, expected pulses queued by stimulus and popped by a monitor.
module tb_input_conditioner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] raw_in = 8'hFF;
    logic [7:0] level, rise, fall, hold;
    logic       any_rise, tick;

    input_conditioner #(
        .WIDTH(8), .TICK_DIV(4), .STABLE_TICKS(3), .LONG_TICKS(4)
    ) dut (
        .clk(clk), .reset(reset), .ena(ena), .raw_in(raw_in),
        .level(level), .rise(rise), .fall(fall), .any_rise(any_rise),
        .tick(tick), .hold(hold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] r, f, h, l;
        int lo, hi;
    } ev_t;
    ev_t q[$];
    ev_t mon_e;
    int tests = 0;
    int fails = 0;

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(logic [7:0] r, logic [7:0] f, logic [7:0] h, logic [7:0] l, int lo, int hi);
        ev_t e;
        e.r = r; e.f = f; e.h = h; e.l = l;
        e.lo = cyc + lo; e.hi = cyc + hi;
        q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        while (q.size() != 0 && i < 100) begin
            step(1);
            i++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d expected pulses never seen, expected 0 pending", q.size());
            q.delete();
        end
    endtask

    // Every pulse on rise/fall/hold must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && (rise | fall | hold) != 8'h00) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got rise=%h fall=%h hold=%h at cycle %0d, expected none",
                         rise, fall, hold, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("rise", {24'h0, rise}, {24'h0, mon_e.r});
                chk("fall", {24'h0, fall}, {24'h0, mon_e.f});
                chk("hold", {24'h0, hold}, {24'h0, mon_e.h});
                chk("level", {24'h0, level}, {24'h0, mon_e.l});
                chk("any_rise", {31'h0, any_rise}, {31'h0, mon_e.r != 8'h00});
                tests++;
                if (cyc < mon_e.lo || cyc > mon_e.hi) begin
                    fails++;
                    $display("FAIL latency: pulse at cycle %0d, expected %0d..%0d", cyc, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int tsum;
        step(3);
        chk("reset_level", {24'h0, level}, 32'h0);
        chk("reset_rise_fall", {16'h0, rise, fall}, 32'h0);
        chk("reset_tick_any", {30'h0, tick, any_rise}, 32'h0);
        chk("reset_hold", {24'h0, hold}, 32'h0);

        reset = 1'b0;
        expect_ev(8'hFF, 8'h00, 8'h00, 8'hFF, 11, 14);
        wait_idle();
        raw_in = 8'h00;
        expect_ev(8'h00, 8'hFF, 8'h00, 8'h00, 11, 14);
        wait_idle();

        raw_in = 8'h10;
        expect_ev(8'h10, 8'h00, 8'h00, 8'h10, 11, 14);
        wait_idle();
        raw_in = 8'h00;
        expect_ev(8'h00, 8'h10, 8'h00, 8'h00, 11, 14);
        wait_idle();

        raw_in = 8'h01;
        step(5);
        raw_in = 8'h00;
        step(30);
        chk("glitch_level", {24'h0, level}, 32'h0);

        tsum = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            tsum += int'(tick);
        end
        chk("tick_count_40", tsum, 10);

        ena = 1'b0;
        raw_in = 8'h04;
        tsum = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            tsum += int'(tick);
        end
        chk("ena_off_ticks", tsum, 0);
        chk("ena_off_level", {24'h0, level}, 32'h0);
        ena = 1'b1;
        expect_ev(8'h04, 8'h00, 8'h00, 8'h04, 9, 12);
        wait_idle();
        raw_in = 8'h00;
        expect_ev(8'h00, 8'h04, 8'h00, 8'h00, 11, 14);
        wait_idle();

        raw_in = 8'h08;
        expect_ev(8'h08, 8'h00, 8'h00, 8'h08, 11, 14);
        wait_idle();
        raw_in = 8'h28;
        step(7);
        reset = 1'b1;
        #1;
        chk("midreset_level", {24'h0, level}, 32'h0);
        chk("midreset_pulses", {8'h0, rise, fall, hold}, 32'h0);
        chk("midreset_tick", {31'h0, tick}, 32'h0);
        raw_in = 8'h00;
        step(2);
        reset = 1'b0;
        step(40);
        chk("post_reset_level", {24'h0, level}, 32'h0);

        raw_in = 8'h80;
        expect_ev(8'h80, 8'h00, 8'h00, 8'h80, 11, 14);
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
        expect_ev(8'h00, 8'h00, 8'h80, 8'h80, 27, 30);
`endif
        wait_idle();
        step(30);
        chk("long_level", {24'h0, level}, 32'h80);
        raw_in = 8'h00;
        expect_ev(8'h00, 8'h80, 8'h00, 8'h00, 11, 14);
        wait_idle();
        step(5);
        chk("queue_empty", q.size(), 0);
        chk("final_hold", {24'h0, hold}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
